// File: rtl/updi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : updi_pkg
// Purpose : Shared state encoding, UPDI frame layout constants and parity
//           helper for the UPDI link sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package updi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_TX    = 3'd2,
        ST_RX    = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Frame layout, LSB first on the wire: start, data, parity, stop, stop
    localparam int         FRM_START_POS = 0;
    localparam int         FRM_DATA_POS  = 1;
    localparam logic       START_VAL     = 1'b0;
    localparam logic [1:0] STOP_VAL      = 2'b11;

    function automatic logic parity16(input logic [15:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updi_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : updi_link_ctrl_if
// Purpose : Command-in / response-out streaming bus of the UPDI sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface updi_link_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_last;
    logic [ADDR_W-1:0] i_rx_len;
    logic              o_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              i_ready;

    modport slave (
        input  i_valid, i_data, i_last, i_rx_len, i_ready,
        output o_ready, o_valid, o_data, o_last
    );

    modport master (
        output i_valid, i_data, i_last, i_rx_len, i_ready,
        input  o_ready, o_valid, o_data, o_last
    );
endinterface
`default_nettype wire

// File: rtl/updi_frame_codec.sv
`default_nettype none
// ============================================================================
// Module  : updi_frame_codec
// Purpose : Combinational pack of a byte into a UPDI frame and unpack/check
//           of a received frame.
// Revision: 1.0 - initial release
// ============================================================================
module updi_frame_codec
    import updi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MEM_W  = 12
) (
    input  wire logic [DATA_W-1:0] pk_data,
    output logic      [MEM_W-1:0]  pk_frame,
    input  wire logic [MEM_W-1:0]  up_frame,
    output logic      [DATA_W-1:0] up_data,
    output logic                   up_frame_err,
    output logic                   up_par_err
);
    localparam int C_PAR_POS  = FRM_DATA_POS + DATA_W;
    localparam int C_STOP_POS = C_PAR_POS + 1;

    assign pk_frame     = {STOP_VAL, parity16(16'(pk_data)), pk_data, START_VAL};
    assign up_data      = up_frame[FRM_DATA_POS +: DATA_W];
    assign up_frame_err = (up_frame[FRM_START_POS] != START_VAL) ||
                          (up_frame[C_STOP_POS +: 2] != STOP_VAL);
    assign up_par_err   = up_frame[C_PAR_POS] != parity16(16'(up_data));
endmodule
`default_nettype wire

// File: rtl/updi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : updi_link_ctrl
// Purpose : UPDI link sequencer: frames command bytes into buffer memory, runs
//           PHY transmit/receive, then checks and streams the response bytes.
// Revision: 1.0 - initial release
// ============================================================================
module updi_link_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MEM_W   = 12,
    parameter int ADDR_W  = 7,
    parameter int RX_BASE = 64,
    parameter int TMO_CYC = 4096
) (
    input  wire logic              clk,
    input  wire logic              rst,
    updi_link_ctrl_if.slave        bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2:0]             o_err,
    output logic                   o_phy_rst,
    output logic                   o_ten,
    output logic                   o_ren,
    output logic [ADDR_W-1:0]      o_tx_len,
    output logic [ADDR_W-1:0]      o_rx_len,
    input  wire logic              i_tend,
    input  wire logic              i_rend,
    input  wire logic              i_phy_csb0,
    input  wire logic              i_phy_web0,
    input  wire logic [ADDR_W-1:0] i_phy_addr0,
    input  wire logic [MEM_W-1:0]  i_phy_din0,
    output logic [MEM_W-1:0]       o_phy_dout0,
    output logic                   csb0,
    output logic                   web0,
    output logic [ADDR_W-1:0]      addr0,
    output logic [MEM_W-1:0]       din0,
    input  wire logic [MEM_W-1:0]  dout0
);
    import updi_pkg::*;

    localparam int                TMO_W      = $clog2(TMO_CYC) + 1;
    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_RX_BASE  = ADDR_W'(RX_BASE);
    localparam logic [ADDR_W-1:0] C_RX_SPAN  = ADDR_W'(DEPTH - RX_BASE);
    localparam logic [ADDR_W-1:0] C_FILL_END = ADDR_W'(RX_BASE - 1);
    localparam logic [TMO_W-1:0]  C_TMO      = TMO_W'(TMO_CYC - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_wptr, r_rptr, r_rx_len;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_inflight, r_valid, r_last, r_done, r_phy_rst;
    logic [DATA_W-1:0]   r_data;
    logic [2:0]          r_err;
    logic [MEM_W-1:0]    w_pk_frame;
    logic [DATA_W-1:0]   w_up_data;
    logic                w_up_ferr, w_up_perr;
    logic                w_accept, w_beat_last, w_hs, w_issue, w_done_evt, w_timeout;

    updi_frame_codec #(.DATA_W(DATA_W), .MEM_W(MEM_W)) u_codec (
        .pk_data      (bus.i_data),
        .pk_frame     (w_pk_frame),
        .up_frame     (dout0),
        .up_data      (w_up_data),
        .up_frame_err (w_up_ferr),
        .up_par_err   (w_up_perr)
    );

    assign bus.o_ready = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_last  = r_valid & r_last;
    assign o_busy      = r_state != ST_IDLE;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_phy_rst   = r_phy_rst;
    assign o_ten       = r_state == ST_TX;
    assign o_ren       = r_state == ST_RX;
    assign o_tx_len    = r_wptr;
    assign o_rx_len    = r_rx_len;
    assign o_phy_dout0 = dout0;

    // The last TX slot closes the frame even without i_last so TX never spills into RX space
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_beat_last = bus.i_last || (r_wptr == C_FILL_END);
    assign w_hs        = r_valid && bus.i_ready;
    assign w_issue     = (r_state == ST_DRAIN) && !r_inflight &&
                         (r_rptr != r_rx_len) && (!r_valid || w_hs);

    always_comb begin
        w_state_nxt = r_state;
        w_done_evt  = 1'b0;
        w_timeout   = 1'b0;
        csb0        = 1'b1;
        web0        = 1'b1;
        addr0       = r_wptr;
        din0        = w_pk_frame;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    csb0        = 1'b0;
                    web0        = 1'b0;
                    w_state_nxt = w_beat_last ? ST_TX : ST_FILL;
                end
            end
            ST_TX, ST_RX: begin
                csb0  = i_phy_csb0;
                web0  = i_phy_web0;
                addr0 = i_phy_addr0;
                din0  = i_phy_din0;
                if (r_state == ST_TX && i_tend) begin
                    if (r_rx_len == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_evt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RX;
                    end
                end else if (r_state == ST_RX && i_rend) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_tmo == C_TMO) begin
                    w_timeout   = 1'b1;
                    w_done_evt  = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DRAIN: begin
                if (w_issue) begin
                    csb0  = 1'b0;
                    addr0 = C_RX_BASE + r_rptr;
                end
                if (w_hs && r_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_evt  = 1'b1;
                end
            end
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rx_len   <= '0;
            r_tmo      <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_err      <= '0;
            r_done     <= 1'b0;
            r_phy_rst  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_evt;
            r_phy_rst  <= w_timeout;
            r_inflight <= w_issue;

            if (w_state_nxt == ST_IDLE) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_accept) r_wptr <= r_wptr + 1'b1;
                if (w_issue)  r_rptr <= r_rptr + 1'b1;
            end

            if (w_accept && w_beat_last)
                r_rx_len <= (bus.i_rx_len > C_RX_SPAN) ? C_RX_SPAN : bus.i_rx_len;

            if ((r_state == ST_TX || r_state == ST_RX) && w_state_nxt == r_state)
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;

            // Read data arrives the cycle after the issue; r_rptr already counts it
            if (r_inflight) begin
                r_valid <= 1'b1;
                r_data  <= w_up_data;
                r_last  <= r_rptr == r_rx_len;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end

            if (w_accept)
                r_err <= '0;
            else
                r_err <= r_err | {w_timeout, r_inflight & w_up_ferr, r_inflight & w_up_perr};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_updi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_updi_link_ctrl
// Purpose : Self-checking bench for updi_link_ctrl with memory and PHY models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_updi_link_ctrl;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_busy, o_done, o_phy_rst, o_ten, o_ren;
    logic [2:0]  o_err;
    logic [6:0]  o_tx_len, o_rx_len;
    logic        i_tend = 1'b0, i_rend = 1'b0;
    logic        i_phy_csb0 = 1'b1, i_phy_web0 = 1'b1;
    logic [6:0]  i_phy_addr0 = '0;
    logic [11:0] i_phy_din0 = '0;
    logic [11:0] o_phy_dout0, din0, dout0;
    logic        csb0, web0;
    logic [6:0]  addr0;
    logic [11:0] mem [128];

    updi_link_ctrl_if #(.DATA_W(8), .ADDR_W(7)) bus ();

    updi_link_ctrl #(.DATA_W(8), .MEM_W(12), .ADDR_W(7), .RX_BASE(64), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_phy_rst(o_phy_rst),
        .o_ten(o_ten), .o_ren(o_ren), .o_tx_len(o_tx_len), .o_rx_len(o_rx_len),
        .i_tend(i_tend), .i_rend(i_rend),
        .i_phy_csb0(i_phy_csb0), .i_phy_web0(i_phy_web0), .i_phy_addr0(i_phy_addr0),
        .i_phy_din0(i_phy_din0), .o_phy_dout0(o_phy_dout0),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0 <= mem[addr0];
        end
    end

    int          checks = 0, failures = 0;
    int          done_cnt = 0;
    bit          ren_seen = 1'b0;
    logic [8:0]  sb [$];
    logic [8:0]  sb_exp;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [7:0]  p_data = '0;

    typedef struct {
        logic [7:0]      c0, c1;
        logic [6:0]      rx;
        logic [2:0][7:0] r;
        int              bad;
        bit              stall;
        logic [2:0]      err;
    } vec_t;
    vec_t vt [4];

    function automatic logic [11:0] frame(input logic [7:0] b);
        return {2'b11, ^b, b, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return o_ten;
            1:       return o_ren;
            2:       return o_done;
            default: return bus.o_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string nm, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sig(sel)) break;
            if (cyc >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s: got no event after %0d cycles expected event", nm, cyc);
                break;
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] b[$], input bit mark_last, input logic [6:0] rx);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            @(posedge clk); #1;
            bus.i_valid  = 1'b1;
            bus.i_data   = b[i];
            bus.i_last   = mark_last && (i == b.size() - 1);
            bus.i_rx_len = rx;
            n = 0;
            forever begin
                @(negedge clk);
                if (bus.o_ready) break;
                if (++n >= 50) begin
                    checks++; failures++;
                    $display("FAIL accept: got o_ready=0 for %0d cycles expected 1", n);
                    break;
                end
            end
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic pulse_tend();
        repeat (20) @(posedge clk);
        #1 i_tend = 1'b1;
        @(posedge clk); #1 i_tend = 1'b0;
    endtask

    // PHY writes response frames; expected bytes enter the scoreboard as they are written
    task automatic phy_rx(input logic [2:0][7:0] r, input int n, input int bad);
        logic [11:0] w;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            w = frame(r[k]);
            if (k == 0 && bad == 1) w = w ^ 12'h200;
            if (k == 0 && bad == 2) w = w & 12'h7FF;
            i_phy_csb0  = 1'b0;
            i_phy_web0  = 1'b0;
            i_phy_addr0 = 7'(64 + k);
            i_phy_din0  = w;
            sb.push_back({k == n - 1, r[k]});
        end
        @(posedge clk); #1;
        i_phy_csb0 = 1'b1;
        i_phy_web0 = 1'b1;
        i_rend     = 1'b1;
        @(posedge clk); #1 i_rend = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [7:0] q[$];
        int n;
        q = {v.c0, v.c1};
        ren_seen = 1'b0;
        send_cmd(q, 1'b1, v.rx);
        wait_for(0, 50, "ten_rise", n);
        chk("err_cleared", 32'(o_err), 32'(0));
        chk("tx_len", 32'(o_tx_len), 32'(2));
        chk("mem_frame0", 32'(mem[0]), 32'(frame(v.c0)));
        chk("mem_frame1", 32'(mem[1]), 32'(frame(v.c1)));
        pulse_tend();
        if (v.rx != 0) begin
            wait_for(1, 20, "ren_rise", n);
            chk("rx_len", 32'(o_rx_len), 32'(v.rx));
            phy_rx(v.r, int'(v.rx), v.bad);
            if (v.stall) begin
                wait_for(3, 50, "valid_rise", n);
                @(posedge clk); #1 bus.i_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.i_ready = 1'b1;
            end
        end
        wait_for(2, 300, "done", n);
        chk("err_at_done", 32'(o_err), 32'(v.err));
        chk("ren_seen", 32'(ren_seen), 32'(v.rx != 0));
        chk("sb_left", 32'(sb.size()), 32'(0));
        @(negedge clk);
        chk("idle_ready", 32'(bus.o_ready), 32'(1));
        chk("err_sticky", 32'(o_err), 32'(v.err));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (p_valid && !p_ready) begin
                checks++;
                if (!(bus.o_valid && bus.o_data == p_data && bus.o_last == p_last)) begin
                    failures++;
                    $display("FAIL hold_stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             bus.o_valid, bus.o_data, bus.o_last, p_data, p_last);
                end
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL resp_extra: got byte %0h expected none", bus.o_data);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("resp_byte", 32'({bus.o_last, bus.o_data}), 32'(sb_exp));
                end
            end
            if (o_done) done_cnt++;
            if (o_ren)  ren_seen = 1'b1;
        end
        p_valid = bus.o_valid;
        p_ready = bus.i_ready;
        p_data  = bus.o_data;
        p_last  = bus.o_last;
    end

    initial begin
        logic [7:0] q[$];
        int n, d0;

        vt[0] = '{c0: 8'h55, c1: 8'hC0, rx: 7'd0, r: '0, bad: 0, stall: 1'b0, err: 3'b000};
        vt[1] = '{c0: 8'h80, c1: 8'h04, rx: 7'd2, r: {8'h00, 8'hAB, 8'h61}, bad: 0, stall: 1'b0, err: 3'b000};
        vt[2] = '{c0: 8'h3C, c1: 8'hA5, rx: 7'd3, r: {8'h7E, 8'hFF, 8'h00}, bad: 1, stall: 1'b1, err: 3'b001};
        vt[3] = '{c0: 8'h12, c1: 8'h34, rx: 7'd1, r: {8'h00, 8'h00, 8'h5A}, bad: 2, stall: 1'b0, err: 3'b010};

        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_rx_len = '0;
        bus.i_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'(1));
        chk("rst_flags", 32'({bus.o_valid, o_busy, o_done, o_ten, o_ren}), 32'(0));
        chk("rst_err", 32'(o_err), 32'(0));
        chk("rst_mem_ctl", 32'({csb0, web0}), 32'(3));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("phy_rst_after_rst", 32'(o_phy_rst), 32'(1));
        @(negedge clk);
        chk("phy_rst_cleared", 32'(o_phy_rst), 32'(0));

        for (int i = 0; i < 4; i++) begin
            run_txn(vt[i]);
            if (i == 0) begin
                chk("spec_frame_55", 32'(mem[0]), 32'(12'hCAA));
            end
        end

        // PHY never signals transmit end
        send_cmd('{8'h99}, 1'b1, 7'd0);
        wait_for(0, 50, "ten_rise_tmo", n);
        wait_for(2, TMO + 100, "tmo_done", n);
        chk("tmo_cycles_in_range", 32'(n >= TMO - 1 && n <= TMO + 2), 32'(1));
        chk("tmo_err", 32'(o_err), 32'(3'b100));
        chk("tmo_phy_rst", 32'(o_phy_rst), 32'(1));
        chk("tmo_ten_low", 32'(o_ten), 32'(0));
        @(negedge clk);
        chk("tmo_idle", 32'({o_busy, bus.o_ready, o_phy_rst}), 32'(3'b010));

        // Reset in the middle of RX
        d0 = done_cnt;
        send_cmd('{8'h21, 8'h43}, 1'b1, 7'd2);
        wait_for(0, 50, "ten_rise_rst", n);
        pulse_tend();
        wait_for(1, 20, "ren_rise_rst", n);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ren_busy", 32'({o_ren, o_busy}), 32'(0));
        chk("midrst_phy_rst", 32'(o_phy_rst), 32'(1));
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        run_txn(vt[1]);

        // Non-last beats until the last TX slot close the command
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(8'(i * 3 + 1));
        send_cmd(q, 1'b0, 7'd0);
        wait_for(0, 50, "ten_rise_full", n);
        chk("full_tx_len", 32'(o_tx_len), 32'(64));
        chk("full_mem63", 32'(mem[63]), 32'(frame(q[63])));
        chk("full_ready_low", 32'(bus.o_ready), 32'(0));
        pulse_tend();
        wait_for(2, 50, "full_done", n);
        chk("full_err", 32'(o_err), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
